// File: rtl/note_detector.sv
// note_detector: locks onto a square-wave tone and reports which of the notes C..B it matches.
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   audio_in   : asynchronous square-wave input
//   note       : detected note code (0=C .. 6=B), 4'hF when none
//   note_valid : one-cycle pulse on lock acquisition
//   locked     : high while a stable note is tracked
// Optional macro NOTE_DETECTOR_DEGLITCH_EN adds a 4-sample stability filter after the synchronizer.
module note_detector #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int FREQ_C      = 261,
    parameter int FREQ_D      = 294,
    parameter int FREQ_E      = 329,
    parameter int FREQ_F      = 349,
    parameter int FREQ_G      = 392,
    parameter int FREQ_A      = 440,
    parameter int FREQ_B      = 493,
    parameter int TOL_SHIFT   = 5,
    parameter int MATCH_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       audio_in,
    output logic [3:0] note,
    output logic       note_valid,
    output logic       locked
);
    typedef enum logic [1:0] {IDLE, ARM, LOCKED} state_t;

    function automatic logic [31:0] nom(input int f);
        return 32'(2 * (CLK_FREQ / (2 * f)));
    endfunction

    function automatic logic hit(input logic [31:0] p, input logic [31:0] n);
        return (p >= n - (n >> TOL_SHIFT)) && (p <= n + (n >> TOL_SHIFT));
    endfunction

    localparam logic [31:0] N_C = nom(FREQ_C);
    localparam logic [31:0] N_D = nom(FREQ_D);
    localparam logic [31:0] N_E = nom(FREQ_E);
    localparam logic [31:0] N_F = nom(FREQ_F);
    localparam logic [31:0] N_G = nom(FREQ_G);
    localparam logic [31:0] N_A = nom(FREQ_A);
    localparam logic [31:0] N_B = nom(FREQ_B);
    localparam logic [31:0] TMO = (32'd4 * N_C) / 32'd2;
    localparam logic [7:0]  MC  = 8'(MATCH_COUNT);

    logic [1:0]  r_sync;
    logic        r_prev;
    logic [31:0] r_cnt;
    logic [7:0]  r_mcnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_note;
    logic        r_valid;
    logic        r_locked;
    state_t      r_state;

    logic        w_level;
    logic        w_edge;
    logic [3:0]  w_code;
    logic        w_hit;
    logic [7:0]  w_m1;
    logic        w_timeout;
    state_t      w_state_n;
    logic [31:0] w_cnt_n;
    logic [7:0]  w_mcnt_n;
    logic [3:0]  w_cand_n;
    logic [3:0]  w_note_n;
    logic        w_valid_n;
    logic        w_locked_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], audio_in};
            r_prev <= w_level;
        end
    end

`ifdef NOTE_DETECTOR_DEGLITCH_EN
    logic [3:0] r_hist;
    logic       r_filt;
    // Level only moves once the last four synchronized samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[2:0], r_sync[1]};
            r_filt <= (&r_hist) ? 1'b1 : (~|r_hist) ? 1'b0 : r_filt;
        end
    end
    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif

    assign w_edge = w_level & ~r_prev;

    // Counter is set to 1 on an edge so that at the next edge it equals the period.
    // Overlapping bands resolve to the lowest code through the ordering below.
    assign w_code = hit(r_cnt, N_C) ? 4'd0 :
                    hit(r_cnt, N_D) ? 4'd1 :
                    hit(r_cnt, N_E) ? 4'd2 :
                    hit(r_cnt, N_F) ? 4'd3 :
                    hit(r_cnt, N_G) ? 4'd4 :
                    hit(r_cnt, N_A) ? 4'd5 :
                    hit(r_cnt, N_B) ? 4'd6 : 4'hF;
    assign w_hit     = w_code != 4'hF;
    assign w_m1      = (w_code == r_cand) ? r_mcnt + 8'd1 : 8'd1;
    assign w_timeout = (r_cnt >= TMO) && !w_edge;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = w_edge ? 32'd1 : (r_cnt >= TMO) ? TMO : r_cnt + 32'd1;
        w_mcnt_n   = r_mcnt;
        w_cand_n   = r_cand;
        w_note_n   = r_note;
        w_valid_n  = 1'b0;
        w_locked_n = r_locked;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_n = ARM;
                    w_mcnt_n  = 8'd0;
                    w_cand_n  = 4'hF;
                end
            end
            ARM: begin
                if (w_edge) begin
                    w_cand_n = w_code;
                    w_mcnt_n = w_hit ? w_m1 : 8'd0;
                    if (w_hit && w_m1 >= MC) begin
                        w_state_n  = LOCKED;
                        w_note_n   = w_code;
                        w_locked_n = 1'b1;
                        w_valid_n  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_n = IDLE;
                    w_mcnt_n  = 8'd0;
                    w_cand_n  = 4'hF;
                end
            end
            LOCKED: begin
                if (w_edge && w_code != r_note) begin
                    w_state_n  = ARM;
                    w_locked_n = 1'b0;
                    w_note_n   = 4'hF;
                    w_cand_n   = w_code;
                    w_mcnt_n   = w_hit ? 8'd1 : 8'd0;
                end else if (w_timeout) begin
                    w_state_n  = IDLE;
                    w_locked_n = 1'b0;
                    w_note_n   = 4'hF;
                    w_mcnt_n   = 8'd0;
                    w_cand_n   = 4'hF;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcnt   <= '0;
            r_cand   <= 4'hF;
            r_note   <= 4'hF;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_mcnt   <= w_mcnt_n;
            r_cand   <= w_cand_n;
            r_note   <= w_note_n;
            r_valid  <= w_valid_n;
            r_locked <= w_locked_n;
        end
    end

    assign note       = r_note;
    assign note_valid = r_valid;
    assign locked     = r_locked;
endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed checks of note_detector with CLK_FREQ scaled down to 500 kHz.
// Nominal periods at 500 kHz: C=1914 D=1700 E=1518 F=1432 A=1136; timeout 3828 cycles.
module tb_note_detector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       audio_in = 1'b0;
    logic [3:0] note;
    logic       note_valid;
    logic       locked;
    int         errs = 0;
    int         checks = 0;
    int         vcount = 0;

    note_detector #(.CLK_FREQ(500_000)) dut (
        .clk(clk),
        .rst(rst),
        .audio_in(audio_in),
        .note(note),
        .note_valid(note_valid),
        .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (note_valid === 1'b1) vcount <= vcount + 1;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tone(input int p, input int n);
        repeat (n) begin
            audio_in = 1'b1;
            cyc(p / 2);
            audio_in = 1'b0;
            cyc(p - p / 2);
        end
    endtask

    // A tone with a 2-cycle high pulse in the middle of each low phase.
    task automatic glitch_tone(input int n);
        repeat (n) begin
            audio_in = 1'b1;
            cyc(568);
            audio_in = 1'b0;
            cyc(283);
            audio_in = 1'b1;
            cyc(2);
            audio_in = 1'b0;
            cyc(283);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] n, input logic l, input int v);
        chk({tag, "_note"}, 32'(note), 32'(n));
        chk({tag, "_locked"}, 32'(locked), 32'(l));
        chk({tag, "_vcount"}, 32'(vcount), 32'(v));
    endtask

    initial begin
        cyc(3);
        chk("reset_valid", 32'(note_valid), 32'd0);
        chk_out("reset", 4'hF, 1'b0, 0);
        rst = 1'b0;
        cyc(2);
        tone(1136, 3);
        chk_out("a_prelock", 4'hF, 1'b0, 0);
        tone(1136, 1);
        chk_out("a_lock", 4'd5, 1'b1, 1);
        tone(1700, 1);
        chk_out("a_hold", 4'd5, 1'b1, 1);
        tone(1700, 1);
        chk_out("d_unlock", 4'hF, 1'b0, 1);
        tone(1700, 2);
        chk_out("d_lock", 4'd1, 1'b1, 2);
        tone(1600, 1);
        chk_out("d_hold", 4'd1, 1'b1, 2);
        tone(1600, 6);
        chk_out("gap_nolock", 4'hF, 1'b0, 2);
        tone(1914, 4);
        chk_out("c_lock", 4'd0, 1'b1, 3);
        cyc(1900);
        chk_out("c_pre_timeout", 4'd0, 1'b1, 3);
        cyc(30);
        chk_out("c_timeout", 4'hF, 1'b0, 3);
        tone(1171, 4);
        chk_out("a_max_lock", 4'd5, 1'b1, 4);
        tone(1172, 1);
        tone(1172, 4);
        chk_out("a_max_plus1", 4'hF, 1'b0, 4);
        tone(1474, 1);
        tone(1474, 3);
        chk_out("ef_overlap", 4'd2, 1'b1, 5);
        tone(1518, 1);
        audio_in = 1'b1;
        cyc(759);
        audio_in = 1'b0;
        cyc(300);
        chk_out("e_before_rst", 4'd2, 1'b1, 5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_out("e_rst", 4'hF, 1'b0, 5);
        cyc(459);
        tone(1518, 3);
        chk_out("e_relock_pre", 4'hF, 1'b0, 5);
        tone(1518, 1);
        chk_out("e_relock", 4'd2, 1'b1, 6);
        tone(1400, 1);
        tone(1400, 3);
        chk_out("f_lock", 4'd3, 1'b1, 7);
        glitch_tone(5);
`ifdef NOTE_DETECTOR_DEGLITCH_EN
        chk_out("glitch_a", 4'd5, 1'b1, 8);
`else
        chk_out("glitch_a", 4'hF, 1'b0, 7);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
